lifo_serial_tx: RTL and testbench
=================================

// Module: lifo_serial_tx
// PURPOSE
//  Transmit side for the 8x4 LIFO path. Nibbles are pushed in parallel onto
//  an internal LIFO stack. When transmit is enabled, the top entry is popped
//  and shifted out serially, one bit per clk, with a framing strobe.
//  It is the parallel-in/serial-out counterpart to the serial-in shift
//  register (SSBR) chain.
// PARAMETERS
//  WIDTH     4   bits per entry, and serial frame length in cycles
//  DEPTH     8   stack entries (power of two)
//  MSB_FIRST 1   1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
// PORTS
//  clk        in   1              single clock; all state changes on the rising edge
//  rst_n      in   1              synchronous, active-low reset
//  push       in   1              write request; accepted when push && !full
//  push_data  in   WIDTH          entry to push
//  tx_en      in   1              allows a pop/transmit to start from IDLE
//  full       out  1              count==DEPTH (registered)
//  empty      out  1              count==0 (registered)
//  count      out  $clog2(DEPTH)+1  current number of entries
//  sdata      out  1              serial data bit
//  sframe     out  1              high for exactly WIDTH cycles per frame
//  sdone      out  1              1-cycle pulse coincident with last bit of frame
// BEHAVIOUR
//  Reset: while rst_n=0 at an edge, all of these clear:
//   - count=0, empty=1, full=0
//   - sdata=0, sframe=0, sdone=0, state=IDLE, bit_cnt=0
//   - stack contents don't-care
//   Reset mid-frame aborts the frame; the popped entry is lost.
//  Push: accepted on an edge with push=1 && full=0. The entry is written at
//   index count, and count increments. Push while full is dropped silently;
//   count and contents are unchanged.
//  FSM IDLE:
//   - At an edge with tx_en=1 && empty=0: pop. shreg<=stack[count-1],
//     count decrements, bit_cnt<=0, go to SHIFT.
//   - Otherwise stay in IDLE; sframe=0, sdata=0.
//  FSM SHIFT:
//   - sframe=1; sdata=shreg[WIDTH-1] (MSB_FIRST) or shreg[0].
//   - Each edge shifts shreg by one and increments bit_cnt.
//   - While bit_cnt==WIDTH-1: sdone=1. The next edge returns to IDLE.
//   - tx_en is ignored once a frame has started; frames always complete.
//  Outputs are registered. The pop edge is E; bit 0 of the frame is visible
//   in the cycle after E, and the last bit is visible in cycle E+WIDTH.
//   Minimum gap between frames is 1 IDLE cycle, so the period is WIDTH+1.
//  Simultaneous push and pop at the same edge:
//   - The pop reads stack[count-1] (the old top).
//   - The push writes at index count-1, the freed slot.
//   - Net count is unchanged.
//   - full gates push on the pre-edge value, so a push at full is dropped
//     even when a pop happens on that same edge.
//  Push while empty with tx_en=1: no pop at that edge (empty was 1). The
//   pushed entry is popped at the following edge.
//  Push during SHIFT is allowed and does not affect the frame in flight.
//  count never wraps: push is gated by full, pop is gated by empty.
// STRUCTURE
//  Package lifo_tx_pkg holds:
//   - WIDTH/DEPTH defaults
//   - CNT_W=$clog2(DEPTH)+1
//   - state encoding: IDLE=1'b0, SHIFT=1'b1
//  Sub-module piso_shift_reg #(WIDTH,MSB_FIRST) holds the load/shift
//   register and exposes serial out. This module keeps the stack array,
//   the count, and the FSM.
// TESTING
//  1 Hold rst_n=0 for 2 clk -> count=0, empty=1, full=0, sframe=0, sdata=0.
//  2 Push 4'hA, 4'h5, 4'hC, then tx_en=1 (MSB_FIRST=1):
//    - frames out C=1100, then 5=0101, then A=1010
//    - 1 idle cycle between frames; sdone on each 4th bit
//    - empty=1 after the third pop
//  3 Push 9 entries (0..8) with tx_en=0 -> full=1 after 8 pushes; 9th dropped;
//    count=8; the first frame sent is 4'h7.
//  4 count=3; push 4'hF on the same edge as a pop -> the pop frame is the old
//    top; count stays 3; the next frame is 4'hF.
//  5 Drive rst_n=0 in the 2nd bit of a frame -> the next cycle shows sframe=0,
//    count=0, IDLE; no sdone pulse.
//  6 Toggle tx_en low mid-frame -> the frame still completes all WIDTH bits;
//    no new pop occurs while tx_en=0.

Source files
------------

// File: rtl/lifo_tx_pkg.sv
// Shared defaults and FSM encoding for the LIFO serial transmit path.
package lifo_tx_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned CNT_W     = $clog2(DEPTH_DEF) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, serial-out shift register; zeros are shifted in behind the data.
module piso_shift_reg #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             sout
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data;
        end else if (shift) begin
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/lifo_serial_tx.sv
// LIFO stack of WIDTH-bit entries; the top entry is popped and sent serially with a frame strobe.
module lifo_serial_tx
    import lifo_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   tx_en,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   sdata,
    output logic                   sframe,
    output logic                   sdone
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW:0] FULL_CNT = (IW + 1)'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop, last_bit, ser_bit;
    logic [IW-1:0]    rd_idx, wr_idx;
    logic [WIDTH-1:0] stack_q [DEPTH];

    always_comb begin
        push_ok   = push && !full_q;
        pop       = (state_q == IDLE) && tx_en && !empty_q;
        last_bit  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
        rd_idx    = IW'(count_q - 1'b1);
        // A push coinciding with a pop reuses the slot the pop just freed.
        wr_idx    = pop ? rd_idx : count_q[IW-1:0];

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (last_bit) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_q[wr_idx] <= push_data;
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pop),
        .load_data (stack_q[rd_idx]),
        .shift     (state_q == SHIFT),
        .sout      (ser_bit)
    );

    assign sframe = (state_q == SHIFT);
    assign sdata  = sframe & ser_bit;
    assign sdone  = last_bit;
    assign full   = full_q;
    assign empty  = empty_q;
    assign count  = count_q;

endmodule

// File: tb/tb_lifo_serial_tx.sv
// Directed bench for lifo_serial_tx: expected frames queued by stimulus, checked by a frame monitor.
module tb_lifo_serial_tx;

    localparam int unsigned W = 4;
    localparam int unsigned D = 8;

    logic         clk = 1'b0;
    logic         rst_n, push, tx_en;
    logic [W-1:0] push_data;
    logic         full, empty, sdata, sframe, sdone;
    logic [3:0]   count;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] sb[$];
    int           starts[$];
    int           cyc   = 0;
    int           nbits = 0;
    logic [W-1:0] acc   = '0;

    always #5 clk = ~clk;

    lifo_serial_tx #(
        .WIDTH     (W),
        .DEPTH     (D),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .tx_en     (tx_en),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .sdata     (sdata),
        .sframe    (sframe),
        .sdone     (sdone)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame monitor: assembles MSB-first bits and compares each completed frame.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            nbits = 0;
        end else if (sframe) begin
            if (nbits == 0) starts.push_back(cyc);
            acc = {acc[W-2:0], sdata};
            nbits++;
            if (sdone) begin
                chk("frame_len", nbits, W);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got 0x%0h expected no frame", acc);
                end else begin
                    chk("frame_data", acc, sb.pop_front());
                end
                nbits = 0;
            end else if (nbits >= W) begin
                chk("sdone_on_last_bit", sdone, 1'b1);
                nbits = 0;
            end
        end else begin
            if (nbits != 0) chk("frame_truncated", nbits, W);
            nbits = 0;
            chk("idle_sdata", sdata, 1'b0);
            chk("idle_sdone", sdone, 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [W-1:0] v);
        push      = 1'b1;
        push_data = v;
        tick();
        push      = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int i;
        i = 0;
        while ((sb.size() != 0 || sframe) && i < maxc) begin
            tick();
            i++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; tx_en = 1'b0; push_data = '0;

        // Reset state
        repeat (2) tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_sframe", sframe, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_sdone", sdone, 0);
        rst_n = 1'b1;
        tick();

        // Three entries out in LIFO order, back-to-back frames
        starts.delete();
        do_push(4'hA); do_push(4'h5); do_push(4'hC);
        chk("t2_count", count, 3);
        sb.push_back(4'hC); sb.push_back(4'h5); sb.push_back(4'hA);
        tx_en = 1'b1;
        drain(60);
        tx_en = 1'b0;
        chk("t2_empty", empty, 1);
        chk("t2_count_end", count, 0);
        chk("t2_nframes", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("t2_period_1", starts[1] - starts[0], W + 1);
            chk("t2_period_2", starts[2] - starts[1], W + 1);
        end

        // Fill to full, ninth push dropped
        for (int v = 0; v < 9; v++) begin
            do_push(4'(v));
            if (v == 7) begin
                chk("t3_full_at_8", full, 1);
                chk("t3_count_8", count, 8);
            end
        end
        chk("t3_count_after_9", count, 8);
        chk("t3_full_after_9", full, 1);
        for (int v = 7; v >= 0; v--) sb.push_back(4'(v));
        tx_en = 1'b1;
        tick();
        chk("t3_full_after_pop", full, 0);
        chk("t3_count_after_pop", count, 7);
        drain(120);
        tx_en = 1'b0;
        chk("t3_empty", empty, 1);

        // Push coinciding with pop
        do_push(4'h1); do_push(4'h2); do_push(4'h3);
        sb.push_back(4'h3);
        tx_en = 1'b1; push = 1'b1; push_data = 4'hF;
        tick();
        push = 1'b0;
        chk("t4_count_same", count, 3);
        chk("t4_sframe", sframe, 1);
        sb.push_back(4'hF); sb.push_back(4'h2); sb.push_back(4'h1);
        drain(60);
        tx_en = 1'b0;
        chk("t4_empty", empty, 1);

        // Push into empty stack with tx_en high, then reset during bit 1
        tx_en = 1'b1; push = 1'b1; push_data = 4'h9;
        tick();
        push = 1'b0;
        chk("t5_no_pop_when_empty", sframe, 0);
        chk("t5_count_1", count, 1);
        tick();
        chk("t5_pop_next_edge", sframe, 1);
        chk("t5_count_0", count, 0);
        tx_en = 1'b0;
        tick();
        chk("t5_bit1_sframe", sframe, 1);
        rst_n = 1'b0;
        tick();
        chk("t5_abort_sframe", sframe, 0);
        chk("t5_abort_count", count, 0);
        chk("t5_abort_empty", empty, 1);
        chk("t5_abort_sdone", sdone, 0);
        rst_n = 1'b1;
        tick();
        chk("t5_idle_after", sframe, 0);

        // tx_en dropped mid-frame
        do_push(4'hB); do_push(4'hD);
        sb.push_back(4'hD);
        tx_en = 1'b1;
        tick();
        tx_en = 1'b0;
        chk("t6_sframe", sframe, 1);
        chk("t6_count", count, 1);
        repeat (8) tick();
        chk("t6_no_new_pop", count, 1);
        chk("t6_idle", sframe, 0);
        chk("t6_queue", sb.size(), 0);
        sb.push_back(4'hB);
        tx_en = 1'b1;
        drain(40);
        tx_en = 1'b0;
        chk("t6_empty", empty, 1);

        repeat (3) tick();
        chk("final_queue", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
